// File: rtl/seg_pkg.sv
// Shared definitions for the multi-digit seven-segment driver.
// Holds the active-low 0-F segment table (bit 7 = DP, always off in the table),
// the blank and dash patterns, and the controller state type.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Entry n is the pattern for nibble n; entry 15 is listed first.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } seg_state_t;

endpackage

// File: rtl/seg_multi_display_if.sv
// Request/status bundle between game logic and the seven-segment driver.
//   load_i      one-cycle capture request
//   value_i     binary value to show
//   dec_mode_i  1 = decimal, 0 = hex
//   lzb_en_i    leading-zero blanking enable
//   dp_i        per-digit decimal point enable
//   blink_en_i  whole-display blink enable (live)
//   busy_o      load in progress
//   done_o      one-cycle pulse when seg_o takes the new value
//   overflow_o  last value did not fit the display
//   seg_o       active-low segments, digit k at [8k+7:8k], bit 7 = DP
interface seg_multi_display_if #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VALUE_W    = 20
);

    logic                      load_i;
    logic [VALUE_W-1:0]        value_i;
    logic                      dec_mode_i;
    logic                      lzb_en_i;
    logic [NUM_DIGITS-1:0]     dp_i;
    logic                      blink_en_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      overflow_o;
    logic [NUM_DIGITS*8-1:0]   seg_o;

    modport master (
        output load_i, value_i, dec_mode_i, lzb_en_i, dp_i, blink_en_i,
        input  busy_o, done_o, overflow_o, seg_o
    );

    modport slave (
        input  load_i, value_i, dec_mode_i, lzb_en_i, dp_i, blink_en_i,
        output busy_o, done_o, overflow_o, seg_o
    );

endinterface

// File: rtl/seg_nibble_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup (DP off).
//   nibble   4-bit digit value 0-F
//   pattern  segment pattern, bit 7 = DP
module seg_nibble_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    assign pattern = SEG_LUT[nibble];

endmodule

// File: rtl/seg_multi_display.sv
// Multi-digit seven-segment driver: shows a captured binary value in hex or
// decimal (sequential double-dabble), with leading-zero blanking, per-digit
// decimal points, overflow dashes and whole-display blinking.
//   clk     system clock
//   resetN  synchronous active-low reset
//   bus     request/status bundle (slave side), see seg_multi_display_if
module seg_multi_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VALUE_W    = 20,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                 clk,
    input  logic                 resetN,
    seg_multi_display_if.slave   bus
);

    localparam int unsigned HEX_W    = 4 * NUM_DIGITS;
    localparam int unsigned EXT_W    = (VALUE_W > HEX_W) ? VALUE_W : HEX_W;
    localparam int unsigned CONV_CW  = $clog2(VALUE_W);
    localparam int unsigned BLINK_CW = $clog2(BLINK_DIV);

    seg_state_t state_q, state_d;

    logic [VALUE_W-1:0]          cap_value_q, cap_value_d;
    logic                        cap_dec_q, cap_dec_d;
    logic                        cap_lzb_q, cap_lzb_d;
    logic [NUM_DIGITS-1:0]       cap_dp_q, cap_dp_d;
    logic [HEX_W-1:0]            bcd_q, bcd_d;
    logic                        bcd_ovf_q, bcd_ovf_d;
    logic [CONV_CW-1:0]          conv_cnt_q, conv_cnt_d;
    logic [HEX_W-1:0]            dig_q, dig_d;
    logic                        dig_ovf_q, dig_ovf_d;
    logic                        pend_q, pend_d;
    logic [NUM_DIGITS-1:0][7:0]  seg_q, seg_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        ovf_q, ovf_d;
    logic [BLINK_CW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                        phase_q, phase_d;

    logic [HEX_W-1:0]            bcd_adj;
    logic [HEX_W-1:0]            bcd_shift;
    logic                        bcd_carry;
    logic [EXT_W-1:0]            val_ext;
    logic [HEX_W-1:0]            hex_dig;
    logic                        hex_ovf;
    logic [NUM_DIGITS-1:0][7:0]  dec_pat;
    logic [NUM_DIGITS-1:0][7:0]  new_seg;
    logic                        seen_nz;

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[HEX_W-2:0], cap_value_q[VALUE_W-1]};
    assign bcd_carry = bcd_adj[HEX_W-1];

    // Zero-extend so the hex window and the bits above it are always in range.
    assign val_ext = EXT_W'(cap_value_q);
    assign hex_dig = val_ext[HEX_W-1:0];
    assign hex_ovf = |(val_ext >> HEX_W);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
        seg_nibble_decode u_dec (
            .nibble  (dig_q[4*k +: 4]),
            .pattern (dec_pat[k])
        );
    end

    // Final per-digit pattern: dash beats blanking, DP applies to everything.
    always_comb begin
        seen_nz = 1'b0;
        new_seg = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (dig_q[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (dig_ovf_q) begin
                new_seg[k] = SEG_DASH;
            end else if (cap_lzb_q && !seen_nz && (k != 0)) begin
                new_seg[k] = SEG_BLANK;
            end else begin
                new_seg[k] = dec_pat[k];
            end
            if (cap_dp_q[k]) begin
                new_seg[k][7] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_value_d = cap_value_q;
        cap_dec_d   = cap_dec_q;
        cap_lzb_d   = cap_lzb_q;
        cap_dp_d    = cap_dp_q;
        bcd_d       = bcd_q;
        bcd_ovf_d   = bcd_ovf_q;
        conv_cnt_d  = conv_cnt_q;
        dig_d       = dig_q;
        dig_ovf_d   = dig_ovf_q;
        pend_d      = pend_q;
        seg_d       = seg_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;

        // Output stage: digit register from UPDATE reaches seg_o one edge later.
        if (pend_q) begin
            seg_d  = new_seg;
            ovf_d  = dig_ovf_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            pend_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.load_i) begin
                    cap_value_d = bus.value_i;
                    cap_dec_d   = bus.dec_mode_i;
                    cap_lzb_d   = bus.lzb_en_i;
                    cap_dp_d    = bus.dp_i;
                    bcd_d       = '0;
                    bcd_ovf_d   = 1'b0;
                    conv_cnt_d  = '0;
                    busy_d      = 1'b1;
                    state_d     = bus.dec_mode_i ? CONVERT : UPDATE;
                end
            end
            CONVERT: begin
                bcd_d       = bcd_shift;
                bcd_ovf_d   = bcd_ovf_q | bcd_carry;
                cap_value_d = {cap_value_q[VALUE_W-2:0], 1'b0};
                conv_cnt_d  = conv_cnt_q + CONV_CW'(1);
                if (conv_cnt_q == CONV_CW'(VALUE_W - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                dig_d     = cap_dec_q ? bcd_q : hex_dig;
                dig_ovf_d = cap_dec_q ? bcd_ovf_q : hex_ovf;
                pend_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Blink counter only runs while enabled; disabling restarts it from phase 0.
    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (bus.blink_en_i) begin
            if (blink_cnt_q == BLINK_CW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_CW'(1);
                phase_d     = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cap_value_q <= '0;
            cap_dec_q   <= 1'b0;
            cap_lzb_q   <= 1'b0;
            cap_dp_q    <= '0;
            bcd_q       <= '0;
            bcd_ovf_q   <= 1'b0;
            conv_cnt_q  <= '0;
            dig_q       <= '0;
            dig_ovf_q   <= 1'b0;
            pend_q      <= 1'b0;
            seg_q       <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_value_q <= cap_value_d;
            cap_dec_q   <= cap_dec_d;
            cap_lzb_q   <= cap_lzb_d;
            cap_dp_q    <= cap_dp_d;
            bcd_q       <= bcd_d;
            bcd_ovf_q   <= bcd_ovf_d;
            conv_cnt_q  <= conv_cnt_d;
            dig_q       <= dig_d;
            dig_ovf_q   <= dig_ovf_d;
            pend_q      <= pend_d;
            seg_q       <= seg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.seg_o      = (bus.blink_en_i && phase_q) ? '1 : seg_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.overflow_o = ovf_q;

endmodule

// File: doc/seg_multi_display.md
# seg_multi_display

Parametrised multi-digit seven-segment driver for the board HEX displays. It takes a binary value and shows it in hex or decimal across `NUM_DIGITS` active-low displays. Decimal conversion is a sequential shift-add-3 (double-dabble) engine. The block adds leading-zero blanking, per-digit decimal points, overflow indication and whole-display blinking. It sits between game logic (score, lives, debug values) and the HEX pins, and replaces per-digit instances of the single-nibble decoder.

## Interface
Parameters:
- `NUM_DIGITS`, 6: number of displays driven; legal 1..8.
- `VALUE_W`, 20: width of the binary input; legal 4..32.
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period; legal ≥ 2.

Ports:
- `clk` in 1: system clock. The block uses one clock only.
- `resetN` in 1: reset, synchronous and active-low.
- `load_i` in 1: one-cycle request to capture and display a new value.
- `value_i` in `VALUE_W`: binary value to display.
- `dec_mode_i` in 1: 1 selects decimal display, 0 selects hex display.
- `lzb_en_i` in 1: enables leading-zero blanking.
- `dp_i` in `NUM_DIGITS`: decimal-point enable per digit; bit k controls digit k.
- `blink_en_i` in 1: enables blinking of the whole display (live input).
- `busy_o` out 1: high while a load is being processed.
- `done_o` out 1: one-cycle pulse when `seg_o` takes the new value.
- `overflow_o` out 1: the last loaded value did not fit in `NUM_DIGITS`.
- `seg_o` out `NUM_DIGITS`×8: per-digit segment pattern, active-low. Bit 7 is the DP. Digit 0 is the least significant digit.

## Operation
- **State machine:** three states, IDLE, CONVERT and UPDATE.
- **IDLE:** `load_i`=1 captures `value_i`, `dec_mode_i`, `lzb_en_i` and `dp_i`, and sets `busy_o`.
  - In hex mode the next state is UPDATE.
  - In decimal mode the next state is CONVERT.
- **Load while busy:** `load_i` is ignored outside IDLE. It is not queued.
- **CONVERT:**
  - Each cycle, add 3 to every BCD nibble that is ≥5, then shift left one bit, taking the next MSB of the captured value.
  - This runs exactly `VALUE_W` cycles, then goes to UPDATE.
  - A 1 shifted out of the top BCD nibble sets a sticky overflow flag.
- **Hex digit source:** the low `4*NUM_DIGITS` bits of the captured value. Overflow = any captured bit above that range is nonzero.
- **UPDATE:** the digit register drives `seg_o`, `overflow_o` updates, `done_o` pulses and `busy_o` clears. Return to IDLE.
- **Decode:** each nibble maps to the standard 0–F pattern (0=C0, 1=F9, … 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E).
- **Leading-zero blanking:** applies only when `lzb_en_i` was captured high. Digits above the most significant nonzero digit become FF. Digit 0 is never blanked, so value 0 shows "0".
- **Overflow display:** every digit shows dash BF. Overflow takes priority over blanking.
- **Decimal point:** `dp_i[k]`=1 clears bit 7 of digit k. This applies to blanked and dash digits too.
- **Blink:**
  - The counter runs 0..`BLINK_DIV`-1 and the phase toggles on wrap.
  - While `blink_en_i`=1 and phase=1, all of `seg_o` = FF.
  - The displayed value registers are not disturbed.
- **Blink counter hold:** the counter runs only while `blink_en_i`=1. It clears to 0 with phase 0 when `blink_en_i`=0.

## Timing
- **Reset values:** `seg_o` all FF, `busy_o`=0, `done_o`=0, `overflow_o`=0, state IDLE, blink counter and phase 0.
- **Reset mid-conversion:** aborts the conversion. Outputs return to the reset values on the next edge.
- **Hex latency:** `load_i` sampled at edge N. `busy_o` is high after N. `seg_o` and `done_o` update at edge N+2.
- **Decimal latency:** `seg_o` and `done_o` update at edge N+`VALUE_W`+2.
- **Back-to-back loads:** the earliest accepted next load is the edge where `done_o` is high (state already IDLE).
- **Output registration:** `seg_o` is registered. The blink gating is the only combinational term on the output path.
- **Input stability:** inputs other than `load_i` and `blink_en_i` need to be stable only at the load edge.

## Structure
- **Package `seg_pkg`:**
  - 16-entry segment pattern constant.
  - `SEG_BLANK`=8'hFF and `SEG_DASH`=8'hBF.
  - State enum `seg_state_t` {IDLE, CONVERT, UPDATE}.
- **Sub-module `seg_nibble_decode`:** combinational nibble→pattern lookup, instantiated once per digit.
- **Top:** contains the FSM, the BCD shift engine, the blanking and overflow logic, and the blink counter.

## Test plan
- **Hex with blanking:** `NUM_DIGITS`=6, hex, lzb=1, value 0x1A3.
  - Digits 0..5 = B0, 88, F9, FF, FF, FF.
  - `done_o` pulses 2 cycles after load.
  - `overflow_o`=0.
- **Decimal maximum, no blanking:** decimal, lzb=0, value 999999, `VALUE_W`=20. All digits 90, `done_o` at load+22.
- **Decimal overflow with DP:** decimal, value 1000000, `dp_i`=6'b000100.
  - `overflow_o`=1.
  - All digits BF except digit 2 = 3F.
- **Zero and ignored reload:** value 0, lzb=1 → digit 0 = C0, others FF. A second `load_i` 3 cycles into a decimal conversion is ignored and only one `done_o` pulse occurs.
- **Blink:** `BLINK_DIV`=4, `blink_en_i`=1. `seg_o` alternates between the value and all FF every 4 cycles. Dropping `blink_en_i` restores the value the next cycle.
- **Reset mid-conversion:** `resetN`=0 during cycle 10 of a conversion. Next edge: `seg_o` all FF, `busy_o`=0, `done_o` never pulses.
